// File: rtl/mem_arb_pkg.sv
// Shared encodings for the byte-serial RAM port arbiter: FSM states, owner ids,
// access-length constants and the IO region tag.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_ICACHE = 1'b0,
      OWN_LSB    = 1'b1
   } owner_t;

   localparam logic [2:0] LEN_B = 3'd1;
   localparam logic [2:0] LEN_H = 3'd2;
   localparam logic [2:0] LEN_W = 3'd4;

   localparam logic [1:0] IO_BASE_HI = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: LSB over icache, accesses serialised into byte cycles.
// Optional IO_STALL_EN: holds IO-region store bytes while io_buffer_full is high.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | port free; grant LSB first, then icache
// ST_READ  | sampling one byte per cycle into the lane buffer
// ST_WRITE | issuing one store byte per cycle, pulse once all are out
module mem_arbiter #(
   parameter int         ADDR_W     = 32,
   parameter int         DATA_W     = 32,
   parameter logic [1:0] IO_BASE_HI = 2'b11
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_branch_in,
   input  logic              icache_req_in,
   input  logic [ADDR_W-1:0] icache_addr_in,
   output logic              mem_to_icache_en_out,
   output logic [DATA_W-1:0] mem_to_icache_data_out,
   input  logic              lsb_req_in,
   input  logic              lsb_wr_in,
   input  logic [ADDR_W-1:0] lsb_addr_in,
   input  logic [2:0]        lsb_len_in,
   input  logic [DATA_W-1:0] lsb_wdata_in,
   output logic              mem_to_lsb_en_out,
   output logic [DATA_W-1:0] mem_to_lsb_data_out,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);
   import mem_arb_pkg::*;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              ic_block_q, ic_block_d;

   logic [ADDR_W-1:0] mem_a_d;
   logic [7:0]        mem_dout_d;
   logic              mem_wr_d;
   logic              ic_en_d, lsb_en_d;
   logic [DATA_W-1:0] ic_data_d, lsb_data_d;

   logic [4:0]        lane;
   logic              lsb_ok, ic_ok;
   logic              stall_grant, stall_write;

   assign lane = {cnt_q[1:0], 3'b000};

`ifdef IO_STALL_EN
   assign stall_grant = io_buffer_full && (lsb_addr_in[17:16] == IO_BASE_HI);
   assign stall_write = io_buffer_full && (addr_q[17:16] == IO_BASE_HI);
`else
   logic unused_io;
   assign stall_grant = 1'b0;
   assign stall_write = 1'b0;
   assign unused_io   = io_buffer_full;
`endif

   // A requester still seeing its own done pulse has not dropped req yet.
   assign lsb_ok = lsb_req_in && !mem_to_lsb_en_out;
   assign ic_ok  = icache_req_in && !mem_to_icache_en_out && !ic_block_q;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      ic_block_d = 1'b0;
      mem_a_d    = mem_a;
      mem_dout_d = mem_dout;
      mem_wr_d   = 1'b0;
      ic_en_d    = 1'b0;
      lsb_en_d   = 1'b0;
      ic_data_d  = mem_to_icache_data_out;
      lsb_data_d = mem_to_lsb_data_out;

      if (!rdy_in) begin
         ic_block_d = ic_block_q;
         ic_en_d    = mem_to_icache_en_out;
         lsb_en_d   = mem_to_lsb_en_out;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (lsb_ok) begin
                  owner_d = OWN_LSB;
                  addr_d  = lsb_addr_in;
                  len_d   = lsb_len_in;
                  wdata_d = lsb_wdata_in;
                  buf_d   = '0;
                  mem_a_d = lsb_addr_in;
                  cnt_d   = 3'd0;
                  if (lsb_wr_in) begin
                     state_d = ST_WRITE;
                     if (!stall_grant) begin
                        mem_dout_d = lsb_wdata_in[7:0];
                        mem_wr_d   = 1'b1;
                        cnt_d      = 3'd1;
                     end
                  end else begin
                     state_d = ST_READ;
                  end
               end else if (ic_ok) begin
                  owner_d = OWN_ICACHE;
                  addr_d  = icache_addr_in;
                  len_d   = LEN_W;
                  buf_d   = '0;
                  mem_a_d = icache_addr_in;
                  cnt_d   = 3'd0;
                  state_d = ST_READ;
               end
            end

            ST_READ: begin
               if (clear_branch_in && owner_q == OWN_ICACHE) begin
                  state_d    = ST_IDLE;
                  cnt_d      = 3'd0;
                  ic_block_d = 1'b1;
               end else begin
                  buf_d[lane +: 8] = mem_din;
                  if (cnt_q + 3'd1 == len_q) begin
                     state_d = ST_IDLE;
                     cnt_d   = 3'd0;
                     if (owner_q == OWN_ICACHE) begin
                        ic_en_d   = 1'b1;
                        ic_data_d = buf_d;
                     end else begin
                        lsb_en_d   = 1'b1;
                        lsb_data_d = buf_d;
                     end
                  end else begin
                     cnt_d   = cnt_q + 3'd1;
                     mem_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
                  end
               end
            end

            ST_WRITE: begin
               if (cnt_q < len_q) begin
                  if (!stall_write) begin
                     mem_a_d    = addr_q + ADDR_W'(cnt_q);
                     mem_dout_d = wdata_q[lane +: 8];
                     mem_wr_d   = 1'b1;
                     cnt_d      = cnt_q + 3'd1;
                  end
               end else begin
                  state_d  = ST_IDLE;
                  cnt_d    = 3'd0;
                  lsb_en_d = 1'b1;
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q                <= ST_IDLE;
         owner_q                <= OWN_ICACHE;
         cnt_q                  <= 3'd0;
         len_q                  <= 3'd0;
         addr_q                 <= '0;
         wdata_q                <= '0;
         buf_q                  <= '0;
         ic_block_q             <= 1'b0;
         mem_a                  <= '0;
         mem_dout               <= 8'd0;
         mem_wr                 <= 1'b0;
         mem_to_icache_en_out   <= 1'b0;
         mem_to_icache_data_out <= '0;
         mem_to_lsb_en_out      <= 1'b0;
         mem_to_lsb_data_out    <= '0;
      end else begin
         state_q                <= state_d;
         owner_q                <= owner_d;
         cnt_q                  <= cnt_d;
         len_q                  <= len_d;
         addr_q                 <= addr_d;
         wdata_q                <= wdata_d;
         buf_q                  <= buf_d;
         ic_block_q             <= ic_block_d;
         mem_a                  <= mem_a_d;
         mem_dout               <= mem_dout_d;
         mem_wr                 <= mem_wr_d;
         mem_to_icache_en_out   <= ic_en_d;
         mem_to_icache_data_out <= ic_data_d;
         mem_to_lsb_en_out      <= lsb_en_d;
         mem_to_lsb_data_out    <= lsb_data_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random loads/stores/fetches
// checked against a byte-array memory model and transaction-level latencies.
module tb_mem_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_branch_in;
   logic        icache_req_in;
   logic [31:0] icache_addr_in;
   logic        mem_to_icache_en_out;
   logic [31:0] mem_to_icache_data_out;
   logic        lsb_req_in, lsb_wr_in;
   logic [31:0] lsb_addr_in;
   logic [2:0]  lsb_len_in;
   logic [31:0] lsb_wdata_in;
   logic        mem_to_lsb_en_out;
   logic [31:0] mem_to_lsb_data_out;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_BASE_HI(2'b11)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_branch_in(clear_branch_in),
      .icache_req_in(icache_req_in), .icache_addr_in(icache_addr_in),
      .mem_to_icache_en_out(mem_to_icache_en_out), .mem_to_icache_data_out(mem_to_icache_data_out),
      .lsb_req_in(lsb_req_in), .lsb_wr_in(lsb_wr_in), .lsb_addr_in(lsb_addr_in),
      .lsb_len_in(lsb_len_in), .lsb_wdata_in(lsb_wdata_in),
      .mem_to_lsb_en_out(mem_to_lsb_en_out), .mem_to_lsb_data_out(mem_to_lsb_data_out),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   // RAM seen by the DUT (aliased on the low 12 address bits) and the bench's own copy.
   logic [7:0]  ram   [0:4095];
   logic [7:0]  model [0:4095];
   assign mem_din = ram[mem_a[11:0]];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] wa_q[$];
   logic [7:0]  wd_q[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_in);
      #1;
      if (mem_wr === 1'b1) begin
         ram[mem_a[11:0]] = mem_dout;
         wa_q.push_back(mem_a);
         wd_q.push_back(mem_dout);
      end
   endtask

   task automatic idle_inputs();
      rdy_in = 1'b1; clear_branch_in = 1'b0; io_buffer_full = 1'b0;
      icache_req_in = 1'b0; icache_addr_in = '0;
      lsb_req_in = 1'b0; lsb_wr_in = 1'b0; lsb_addr_in = '0; lsb_len_in = 3'd0; lsb_wdata_in = '0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr, input int len);
      logic [31:0] r = '0;
      logic [31:0] a;
      for (int i = 0; i < len; i++) begin
         a = addr + i;
         r = r | (32'(model[a[11:0]]) << (8 * i));
      end
      return r;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input int len, input logic [31:0] wdata);
      logic [31:0] a;
      for (int i = 0; i < len; i++) begin
         a = addr + i;
         model[a[11:0]] = wdata[8*i +: 8];
      end
   endfunction

   // Drives one transaction and reports pulse latency in edges (grant edge = 1), -1 on timeout.
   task automatic run_xact(input bit ic, input bit wr, input logic [31:0] addr, input logic [2:0] len,
                           input logic [31:0] wdata, output logic [31:0] data, output int lat,
                           output logic pulse_after);
      bit done = 0;
      wa_q.delete(); wd_q.delete();
      data = '0; lat = 0;
      if (ic) begin
         icache_req_in = 1'b1; icache_addr_in = addr;
      end else begin
         lsb_req_in = 1'b1; lsb_wr_in = wr; lsb_addr_in = addr; lsb_len_in = len; lsb_wdata_in = wdata;
      end
      while (!done && lat < 40) begin
         step();
         lat++;
         if (ic && mem_to_icache_en_out === 1'b1) begin data = mem_to_icache_data_out; done = 1; end
         if (!ic && mem_to_lsb_en_out === 1'b1) begin data = mem_to_lsb_data_out; done = 1; end
      end
      if (!done) lat = -1;
      icache_req_in = 1'b0; lsb_req_in = 1'b0;
      step();
      pulse_after = ic ? mem_to_icache_en_out : mem_to_lsb_en_out;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_in = 1'b1;
      repeat (3) step();
      checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
      checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
      checks++; if (mem_to_icache_en_out !== 1'b0 || mem_to_lsb_en_out !== 1'b0) begin
         errors++; $display("FAIL reset_en got=%b%b exp=00", mem_to_icache_en_out, mem_to_lsb_en_out); end
      checks++; if (mem_to_icache_data_out !== 32'd0 || mem_to_lsb_data_out !== 32'd0) begin
         errors++; $display("FAIL reset_data got=%h/%h exp=0", mem_to_icache_data_out, mem_to_lsb_data_out); end
      rst_in = 1'b0;
      step();
   endtask

   task automatic test_icache_fetch();
      logic [7:0] bytes [4] = '{8'h13, 8'h05, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) begin ram[12'h100 + i] = bytes[i]; model[12'h100 + i] = bytes[i]; end
      icache_req_in = 1'b1; icache_addr_in = 32'h100;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k <= 4) begin
            checks++; if (mem_a !== 32'h100 + k - 1) begin errors++; $display("FAIL fetch_mem_a step=%0d got=%h exp=%h", k, mem_a, 32'h100 + k - 1); end
         end
         checks++; if (mem_to_icache_en_out !== (k == 5)) begin errors++; $display("FAIL fetch_pulse step=%0d got=%b exp=%b", k, mem_to_icache_en_out, k == 5); end
      end
      checks++; if (mem_to_icache_data_out !== 32'h00000513) begin errors++; $display("FAIL fetch_data got=%h exp=00000513", mem_to_icache_data_out); end
      icache_req_in = 1'b0;
      step();
      checks++; if (mem_to_icache_en_out !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width got=%b exp=0", mem_to_icache_en_out); end
   endtask

   task automatic test_store_half();
      logic [31:0] d; int lat; logic pa;
      run_xact(0, 1, 32'h204, 3'd2, 32'h0000ABCD, d, lat, pa);
      model_write(32'h204, 2, 32'h0000ABCD);
      checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got=%0d exp=3", lat); end
      checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL store_write_count got=%0d exp=2", wa_q.size()); end
      checks++; if (wa_q[0] !== 32'h204 || wd_q[0] !== 8'hCD) begin errors++; $display("FAIL store_byte0 got=%h,%h exp=204,cd", wa_q[0], wd_q[0]); end
      checks++; if (wa_q[1] !== 32'h205 || wd_q[1] !== 8'hAB) begin errors++; $display("FAIL store_byte1 got=%h,%h exp=205,ab", wa_q[1], wd_q[1]); end
      checks++; if (pa !== 1'b0) begin errors++; $display("FAIL store_pulse_width got=%b exp=0", pa); end
      run_xact(0, 0, 32'h204, 3'd2, 32'h0, d, lat, pa);
      checks++; if (d !== 32'h0000ABCD || lat !== 3) begin errors++; $display("FAIL store_readback got=%h lat=%0d exp=0000abcd lat=3", d, lat); end
   endtask

   task automatic test_simultaneous();
      int lat = 0, lsb_lat = -1, ic_lat = -1, lsb_cnt = 0;
      logic [31:0] lsb_d = '0, ic_d = '0, a_at3 = '0;
      ram[12'h040] = 8'h5A; model[12'h040] = 8'h5A;
      lsb_req_in = 1'b1; lsb_wr_in = 1'b0; lsb_addr_in = 32'h40; lsb_len_in = 3'd1;
      icache_req_in = 1'b1; icache_addr_in = 32'h500;
      while (ic_lat < 0 && lat < 30) begin
         step();
         lat++;
         if (lat == 3) begin a_at3 = mem_a; lsb_req_in = 1'b0; end
         if (mem_to_lsb_en_out === 1'b1) begin lsb_cnt++; lsb_lat = lat; lsb_d = mem_to_lsb_data_out; end
         if (mem_to_icache_en_out === 1'b1) begin ic_lat = lat; ic_d = mem_to_icache_data_out; end
      end
      icache_req_in = 1'b0;
      step();
      checks++; if (lsb_lat !== 2 || lsb_d !== 32'h5A) begin errors++; $display("FAIL simul_lsb got lat=%0d data=%h exp lat=2 data=5a", lsb_lat, lsb_d); end
      checks++; if (lsb_cnt !== 1) begin errors++; $display("FAIL simul_lsb_once got=%0d exp=1", lsb_cnt); end
      checks++; if (a_at3 !== 32'h500) begin errors++; $display("FAIL simul_ic_grant got=%h exp=500", a_at3); end
      checks++; if (ic_lat !== 7 || ic_d !== model_read(32'h500, 4)) begin
         errors++; $display("FAIL simul_ic got lat=%0d data=%h exp lat=7 data=%h", ic_lat, ic_d, model_read(32'h500, 4)); end
   endtask

   task automatic test_clear_branch();
      int lat = 0, ic_lat = -1;
      logic [31:0] ic_d = '0, d; int l2; logic pa;
      icache_req_in = 1'b1; icache_addr_in = 32'h600;
      while (ic_lat < 0 && lat < 30) begin
         step();
         lat++;
         clear_branch_in = (lat == 2);
         if (mem_to_icache_en_out === 1'b1) begin ic_lat = lat; ic_d = mem_to_icache_data_out; end
      end
      icache_req_in = 1'b0;
      step();
      // abort at G+2, G+3 ignores the held request, re-grant at G+4, pulse at G+8
      checks++; if (ic_lat !== 9) begin errors++; $display("FAIL clear_refetch_latency got=%0d exp=9", ic_lat); end
      checks++; if (ic_d !== model_read(32'h600, 4)) begin errors++; $display("FAIL clear_refetch_data got=%h exp=%h", ic_d, model_read(32'h600, 4)); end
      icache_req_in = 1'b1; icache_addr_in = 32'h640;
      step(); step();
      clear_branch_in = 1'b1; icache_req_in = 1'b0;
      step();
      clear_branch_in = 1'b0;
      run_xact(0, 0, 32'h40, 3'd1, 32'h0, d, l2, pa);
      checks++; if (d !== model_read(32'h40, 1) || l2 !== 2) begin errors++; $display("FAIL clear_lsb_after got=%h lat=%0d exp=%h lat=2", d, l2, model_read(32'h40, 1)); end
      checks++; if (mem_to_icache_data_out !== ic_d) begin errors++; $display("FAIL clear_no_ic_pulse got=%h exp=%h", mem_to_icache_data_out, ic_d); end
   endtask

   task automatic test_rdy_stall();
      int lat = 0, ic_lat = -1;
      logic [31:0] ic_d = '0;
      icache_req_in = 1'b1; icache_addr_in = 32'h700;
      while (ic_lat < 0 && lat < 30) begin
         step();
         lat++;
         if (lat >= 2 && lat <= 5) begin
            checks++; if (mem_a !== 32'h701) begin errors++; $display("FAIL rdy_mem_a_hold step=%0d got=%h exp=701", lat, mem_a); end
         end
         if (lat >= 3 && lat <= 5) begin
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rdy_mem_wr step=%0d got=%b exp=0", lat, mem_wr); end
         end
         rdy_in = !(lat >= 2 && lat <= 4);
         if (mem_to_icache_en_out === 1'b1) begin ic_lat = lat; ic_d = mem_to_icache_data_out; end
      end
      rdy_in = 1'b1; icache_req_in = 1'b0;
      step();
      checks++; if (ic_lat !== 8 || ic_d !== model_read(32'h700, 4)) begin
         errors++; $display("FAIL rdy_result got lat=%0d data=%h exp lat=8 data=%h", ic_lat, ic_d, model_read(32'h700, 4)); end
   endtask

   task automatic test_io_stall();
      int lat = 0, p_lat = -1, w_lat = -1;
`ifdef IO_STALL_EN
      int exp_w = 5, exp_p = 6;
`else
      int exp_w = 1, exp_p = 2;
`endif
      wa_q.delete(); wd_q.delete();
      io_buffer_full = 1'b1;
      lsb_req_in = 1'b1; lsb_wr_in = 1'b1; lsb_addr_in = 32'h30000; lsb_len_in = 3'd1; lsb_wdata_in = 32'h77;
      while (p_lat < 0 && lat < 30) begin
         step();
         lat++;
         if (lat == 4) io_buffer_full = 1'b0;
         if (mem_wr === 1'b1 && w_lat < 0) w_lat = lat;
         if (mem_to_lsb_en_out === 1'b1) p_lat = lat;
      end
      lsb_req_in = 1'b0; io_buffer_full = 1'b0;
      step();
      model_write(32'h30000, 1, 32'h77);
      checks++; if (w_lat !== exp_w) begin errors++; $display("FAIL io_write_step got=%0d exp=%0d", w_lat, exp_w); end
      checks++; if (p_lat !== exp_p) begin errors++; $display("FAIL io_pulse_step got=%0d exp=%0d", p_lat, exp_p); end
      checks++; if (wa_q.size() !== 1 || wa_q[0] !== 32'h30000 || wd_q[0] !== 8'h77) begin
         errors++; $display("FAIL io_write got n=%0d a=%h d=%h exp n=1 a=30000 d=77", wa_q.size(), wa_q[0], wd_q[0]); end
   endtask

   task automatic test_wrap();
      logic [31:0] d; int lat; logic pa;
      run_xact(0, 1, 32'hFFFFFFFE, 3'd4, 32'hC0FFEE11, d, lat, pa);
      model_write(32'hFFFFFFFE, 4, 32'hC0FFEE11);
      checks++; if (wa_q.size() !== 4 || wa_q[1] !== 32'hFFFFFFFF || wa_q[2] !== 32'h0 || wa_q[3] !== 32'h1) begin
         errors++; $display("FAIL wrap_addr got n=%0d %h %h %h exp 4 ffffffff 0 1", wa_q.size(), wa_q[1], wa_q[2], wa_q[3]); end
      run_xact(0, 0, 32'hFFFFFFFE, 3'd4, 32'h0, d, lat, pa);
      checks++; if (d !== 32'hC0FFEE11 || lat !== 5) begin errors++; $display("FAIL wrap_load got=%h lat=%0d exp=c0ffee11 lat=5", d, lat); end
   endtask

   task automatic test_random();
      logic [31:0] addr, wdata, d, exp_d, ea;
      logic [2:0]  len;
      int kind, n, lat, wr_ok;
      logic pa;
      for (int it = 0; it < 60; it++) begin
         kind  = $urandom_range(0, 2);
         addr  = $urandom;
         wdata = $urandom;
         case ($urandom_range(0, 2))
            0:       len = 3'd1;
            1:       len = 3'd2;
            default: len = 3'd4;
         endcase
         n = (kind == 0) ? 4 : int'(len);
         exp_d = model_read(addr, n);
         run_xact(kind == 0, kind == 2, addr, len, wdata, d, lat, pa);
         checks++; if (lat !== n + 1) begin errors++; $display("FAIL rand_latency it=%0d kind=%0d got=%0d exp=%0d", it, kind, lat, n + 1); end
         checks++; if (pa !== 1'b0) begin errors++; $display("FAIL rand_pulse_width it=%0d got=%b exp=0", it, pa); end
         if (kind == 2) begin
            wr_ok = (wa_q.size() == n);
            for (int i = 0; i < n && wr_ok != 0; i++) begin
               ea = addr + i;
               if (wa_q[i] !== ea || wd_q[i] !== wdata[8*i +: 8]) wr_ok = 0;
            end
            model_write(addr, n, wdata);
            checks++; if (wr_ok == 0) begin errors++; $display("FAIL rand_store it=%0d addr=%h len=%0d got n=%0d first=%h,%h exp first=%h,%h", it, addr, n, wa_q.size(), wa_q[0], wd_q[0], addr, wdata[7:0]); end
         end else begin
            checks++; if (d !== exp_d) begin errors++; $display("FAIL rand_load it=%0d kind=%0d addr=%h got=%h exp=%h", it, kind, addr, d, exp_d); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i] = 8'($urandom);
         model[i] = ram[i];
      end
      test_reset();
      test_icache_fetch();
      test_store_half();
      test_simultaneous();
      test_clear_branch();
      test_rdy_stall();
      test_io_stall();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
